// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path constants and helpers
package uart_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 8;
    localparam int DEFAULT_ENTRY_BITS   = DEFAULT_PAYLOAD_BITS + 1;
    localparam int DEFAULT_BREAK_BIT    = DEFAULT_PAYLOAD_BITS;

    // Ceiling log2 for sizing pointers and counters at elaboration time
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    // Stored entry is {break, data}; break sits just above the payload
    function automatic int entry_bits(input int payload_bits);
        return payload_bits + 1;
    endfunction

    function automatic int break_bit(input int payload_bits);
        return payload_bits;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register array, one synchronous write port, asynchronous read port
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DEFAULT_ENTRY_BITS
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_ptr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; the owner masks reads while nothing is held
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with overflow flag; idle timer under UART_RX_FIFO_TIMEOUT_EN
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int PAYLOAD_BITS   = DEFAULT_PAYLOAD_BITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [PAYLOAD_BITS-1:0]  rx_data,
    input  logic                     rx_break,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_BITS-1:0]  out_data,
    output logic                     out_break,
    output logic [clog2(DEPTH):0]    fill_count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     timeout
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_bits(PAYLOAD_BITS);
    localparam int BB = break_bit(PAYLOAD_BITS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          push;
    logic          pop;
    logic          overflow_set;

    assign full      = (fill_count == DEPTH_C);
    assign empty     = (fill_count == '0);
    assign out_valid = !empty;

    assign pop          = out_valid && out_ready;
    assign push         = rx_valid && (!full || pop);
    assign overflow_set = rx_valid && full && !pop && !flush;

    // A BREAK carries no meaningful data, so its payload is stored as zero
    assign wr_entry = rx_break ? {1'b1, {PAYLOAD_BITS{1'b0}}} : {1'b0, rx_data};

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && !flush),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_entry)
    );

    // Head entry reads as zero while the FIFO is empty
    assign out_data  = empty ? '0 : rd_entry[PAYLOAD_BITS-1:0];
    assign out_break = empty ? 1'b0 : rd_entry[BB];

    // Next fill level; flush overrides any concurrent push or pop
    always_comb begin
        count_next = fill_count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = fill_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fill_count - 1'b1;
        end
    end

    // Pointers wrap naturally at DEPTH; the explicit count separates full from empty
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_count <= count_next;
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_cnt;

    // Count idle cycles while data sits unread; saturate at the threshold
    always_ff @(posedge clk) begin
        if (reset || flush || push || (count_next == '0)) begin
            idle_cnt <= '0;
        end else if (!empty && (idle_cnt != TIMEOUT_C)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = (idle_cnt == TIMEOUT_C);
`else
    // Timer not built; the threshold parameter is referenced only to keep the interface uniform
    assign timeout = (TIMEOUT_CYCLES < 0) && 1'b0;
`endif

endmodule
